// File: rtl/delay_pulse_gen_if.sv
// Register-block side of the trigger delay engine.
// master : register block. It drives the static configuration, arm and abort,
//          and reads back status.
// slave  : delay_pulse_gen.
// cfg_*      : configuration fields. The engine latches them when it is armed.
// arm        : level signal. Its rising edge arms the engine.
// abort      : synchronous force-to-IDLE.
// busy       : high while in DELAY, PULSE or GAP.
// armed      : high while in ARMED.
// done       : one-cycle strobe on the last high cycle of the train.
// pulse_idx  : index of the current or the last pulse.
// missed_cnt : saturating count of trigger events seen while busy.
interface delay_pulse_gen_if #(
  parameter int CNT_W    = 24,
  parameter int NPULSE_W = 8,
  parameter int MISS_W   = 8
);
  logic [CNT_W-1:0]    cfg_delay;
  logic [CNT_W-1:0]    cfg_width;
  logic [CNT_W-1:0]    cfg_gap;
  logic [NPULSE_W-1:0] cfg_count;
  logic [1:0]          cfg_edge;
  logic                cfg_rearm;
  logic                arm;
  logic                abort;
  logic                busy;
  logic                armed;
  logic                done;
  logic [NPULSE_W-1:0] pulse_idx;
  logic [MISS_W-1:0]   missed_cnt;

  modport master (
    output cfg_delay, cfg_width, cfg_gap, cfg_count, cfg_edge, cfg_rearm, arm, abort,
    input  busy, armed, done, pulse_idx, missed_cnt
  );

  modport slave (
    input  cfg_delay, cfg_width, cfg_gap, cfg_count, cfg_edge, cfg_rearm, arm, abort,
    output busy, armed, done, pulse_idx, missed_cnt
  );
endinterface

// File: rtl/delay_pulse_gen.sv
// Trigger delay engine (timerclk domain).
// Once armed, the engine waits for a selectable edge or level on the
// asynchronous trigger_in. It then counts cfg_delay cycles and emits a train
// of cfg_count pulses. Each pulse is cfg_width cycles high, and pulses are
// separated by cfg_gap low cycles.
// Ports:
//   timerclk   : sole clock.
//   reset      : asynchronous, active low.
//   trigger_in : asynchronous external trigger. It is synchronised here.
//   trigger    : registered pulse output.
//   bus        : configuration, control and status (delay_pulse_gen_if.slave).
module delay_pulse_gen #(
  parameter int CNT_W       = 24,
  parameter int NPULSE_W    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int MISS_W      = 8
) (
  input  logic              timerclk,
  input  logic              reset,
  input  logic              trigger_in,
  output logic              trigger,
  delay_pulse_gen_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ARMED, DELAY, PULSE, GAP} state_t;

  localparam logic [CNT_W-1:0]    ONE_C = CNT_W'(1);
  localparam logic [NPULSE_W-1:0] ONE_P = NPULSE_W'(1);

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ts, ts_d, evt;
  logic                   arm_q, arm_r, arm_take;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [NPULSE_W-1:0]    idx, idx_n;
  logic [MISS_W-1:0]      missed;
  logic                   busy_q, armed_q, done_c, busy_st;

  logic [CNT_W-1:0]       sh_delay, sh_width, sh_gap;
  logic [NPULSE_W-1:0]    sh_count;
  logic [1:0]             sh_edge;
  logic                   sh_rearm;

  assign ts       = sync_q[SYNC_STAGES-1];
  assign arm_r    = bus.arm & ~arm_q;
  assign arm_take = (state == IDLE) & arm_r & ~bus.abort;
  assign busy_st  = (state == DELAY) | (state == PULSE) | (state == GAP);

  always_comb begin
    evt = 1'b0;
    case (sh_edge)
      2'b00:   evt = ts & ~ts_d;
      2'b01:   evt = ~ts & ts_d;
      2'b10:   evt = ts ^ ts_d;
      default: evt = ts;
    endcase
  end

  // Every counter is loaded with (value - 1) and the move happens on zero.
  // A zero delay skips DELAY entirely. This places the first high cycle
  // exactly delay+1 cycles after the event cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    done_c  = 1'b0;
    case (state)
      IDLE:  if (arm_r) state_n = ARMED;
      ARMED: if (evt) begin
        idx_n = '0;
        if (sh_delay == '0) begin
          state_n = PULSE;
          cnt_n   = sh_width - ONE_C;
        end else begin
          state_n = DELAY;
          cnt_n   = sh_delay - ONE_C;
        end
      end
      DELAY: if (cnt == '0) begin
        state_n = PULSE;
        cnt_n   = sh_width - ONE_C;
      end else cnt_n = cnt - ONE_C;
      PULSE: if (cnt == '0) begin
        if (idx == sh_count - ONE_P) begin
          done_c  = 1'b1;
          state_n = sh_rearm ? ARMED : IDLE;
        end else begin
          idx_n   = idx + ONE_P;
          state_n = GAP;
          cnt_n   = sh_gap - ONE_C;
        end
      end else cnt_n = cnt - ONE_C;
      GAP: if (cnt == '0) begin
        state_n = PULSE;
        cnt_n   = sh_width - ONE_C;
      end else cnt_n = cnt - ONE_C;
      default: state_n = IDLE;
    endcase
    if (bus.abort) begin
      state_n = IDLE;
      cnt_n   = cnt;
      idx_n   = idx;
      done_c  = 1'b0;
    end
  end

  always_ff @(posedge timerclk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      sync_q   <= '0;
      ts_d     <= 1'b0;
      arm_q    <= 1'b0;
      cnt      <= '0;
      idx      <= '0;
      missed   <= '0;
      trigger  <= 1'b0;
      busy_q   <= 1'b0;
      armed_q  <= 1'b0;
      sh_delay <= '0;
      sh_width <= '0;
      sh_gap   <= '0;
      sh_count <= '0;
      sh_edge  <= '0;
      sh_rearm <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], trigger_in};
      ts_d    <= ts;
      arm_q   <= bus.arm;
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      // Status flags are decoded from the next state, so they move on the
      // same edge as the state itself.
      trigger <= (state_n == PULSE);
      busy_q  <= (state_n == DELAY) | (state_n == PULSE) | (state_n == GAP);
      armed_q <= (state_n == ARMED);
      if (arm_take) begin
        sh_delay <= bus.cfg_delay;
        sh_width <= (bus.cfg_width == '0) ? ONE_C : bus.cfg_width;
        sh_gap   <= (bus.cfg_gap   == '0) ? ONE_C : bus.cfg_gap;
        sh_count <= (bus.cfg_count == '0) ? ONE_P : bus.cfg_count;
        sh_edge  <= bus.cfg_edge;
        sh_rearm <= bus.cfg_rearm;
        missed   <= '0;
      end else if (evt & busy_st & ~bus.abort & ~(&missed)) begin
        missed <= missed + 1'b1;
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.armed      = armed_q;
  assign bus.done       = done_c;
  assign bus.pulse_idx  = idx;
  assign bus.missed_cnt = missed;

endmodule

// File: tb/tb_delay_pulse_gen.sv
module tb_delay_pulse_gen;
  localparam int CNT_W = 24, NPULSE_W = 8, SYNC = 2, MISS_W = 8, MAXC = 2048;
  localparam int MISS_MAX = (1 << MISS_W) - 1;

  logic timerclk = 1'b0;
  logic reset = 1'b0;
  logic trigger_in = 1'b0;
  logic trigger;

  delay_pulse_gen_if #(.CNT_W(CNT_W), .NPULSE_W(NPULSE_W), .MISS_W(MISS_W)) bus ();

  delay_pulse_gen #(.CNT_W(CNT_W), .NPULSE_W(NPULSE_W), .SYNC_STAGES(SYNC), .MISS_W(MISS_W)) dut (
    .timerclk  (timerclk),
    .reset     (reset),
    .trigger_in(trigger_in),
    .trigger   (trigger),
    .bus       (bus)
  );

  always #5 timerclk = ~timerclk;

  int passes = 0, total = 0, fails = 0;

  // Scenario stimulus plus expected per-cycle waveforms (cycle 0 = arm cycle).
  bit raw_w[MAXC];
  bit ev[MAXC];
  bit cnt_ev[MAXC];
  bit e_trig[MAXC], e_busy[MAXC], e_armed[MAXC], e_done[MAXC], e_idx_ok[MAXC];
  int e_idx[MAXC], e_miss[MAXC];

  task automatic check(input string tag, input int c, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, c, got, exp);
      $error("%s cyc=%0d got=%0h exp=%0h", tag, c, got, exp);
    end
  endtask

  function automatic bit rawv(input int k);
    return raw_w[(k < 0) ? 0 : k];
  endfunction

  // The trigger level seen by the engine is the raw level SYNC cycles earlier.
  function automatic bit evt_at(input int c, input int m);
    bit a, b;
    a = rawv(c - SYNC);
    b = rawv(c - SYNC - 1);
    case (m)
      0: return a & ~b;
      1: return ~a & b;
      2: return a ^ b;
      default: return a;
    endcase
  endfunction

  // Train-level model: find the accepting event, lay out the pulse train
  // arithmetically, then apply rearm, abort and missed-event accounting.
  task automatic build_model(input int d, input int w, input int g, input int n,
                             input int m, input int rearm, input int ncyc, input int ab);
    int we, ge, ne, per, af, e, st, en, p, off, acc;
    we = (w == 0) ? 1 : w;
    ge = (g == 0) ? 1 : g;
    ne = (n == 0) ? 1 : n;
    per = we + ge;
    for (int c = 0; c < ncyc; c++) begin
      ev[c] = evt_at(c, m);
      cnt_ev[c] = 0; e_trig[c] = 0; e_busy[c] = 0; e_armed[c] = 0;
      e_done[c] = 0; e_idx[c] = 0; e_idx_ok[c] = 0;
    end
    af = 1;
    while (af < ncyc) begin
      e = -1;
      for (int c = af; c < ncyc; c++) if (ev[c]) begin e = c; break; end
      for (int c = af; c < ncyc && (e < 0 || c <= e); c++) e_armed[c] = 1;
      if (e < 0) break;
      st = e + d + 1;
      en = st + ne * we + (ne - 1) * ge - 1;
      for (int c = e + 1; c < ncyc && c <= en; c++) begin
        e_busy[c] = 1;
        cnt_ev[c] = ev[c];
        e_idx_ok[c] = 1;
        if (c >= st) begin
          p = (c - st) / per;
          off = (c - st) % per;
          e_trig[c] = (off < we);
          e_idx[c] = (off < we) ? p : p + 1;
        end else e_idx[c] = 0;
      end
      if (en < ncyc) e_done[en] = 1;
      for (int c = en + 1; c < ncyc; c++) begin e_idx[c] = ne - 1; e_idx_ok[c] = 1; end
      af = rearm ? en + 1 : ncyc;
    end
    if (ab >= 0 && ab < ncyc) begin
      e_done[ab] = 0;
      for (int c = ab + 1; c < ncyc; c++) begin
        e_trig[c] = 0; e_busy[c] = 0; e_armed[c] = 0; e_done[c] = 0;
        e_idx[c] = e_idx[ab]; e_idx_ok[c] = e_idx_ok[ab];
      end
      for (int c = ab; c < ncyc; c++) cnt_ev[c] = 0;
    end
    acc = 0;
    for (int c = 0; c < ncyc; c++) begin
      e_miss[c] = (acc > MISS_MAX) ? MISS_MAX : acc;
      acc += cnt_ev[c];
    end
  endtask

  // Return to IDLE with arm low and trigger_in parked at the scenario's initial level.
  task automatic park();
    @(posedge timerclk); #1;
    bus.arm = 1'b0; bus.abort = 1'b1; trigger_in = raw_w[0];
    @(posedge timerclk); #1;
    bus.abort = 1'b0;
    repeat (4) @(posedge timerclk);
  endtask

  task automatic run_scn(input string tag, input int d, input int w, input int g, input int n,
                         input int m, input int rearm, input int ncyc, input int ab, input bit scr);
    build_model(d, w, g, n, m, rearm, ncyc, ab);
    park();
    for (int c = 0; c < ncyc; c++) begin
      @(posedge timerclk); #1;
      if (c == 0) begin
        bus.cfg_delay = d[CNT_W-1:0];
        bus.cfg_width = w[CNT_W-1:0];
        bus.cfg_gap   = g[CNT_W-1:0];
        bus.cfg_count = n[NPULSE_W-1:0];
        bus.cfg_edge  = m[1:0];
        bus.cfg_rearm = rearm[0];
      end
      if (scr && c == ncyc / 2) begin
        bus.cfg_delay = CNT_W'($urandom_range(20, 40));
        bus.cfg_width = CNT_W'($urandom_range(5, 9));
        bus.cfg_gap   = CNT_W'($urandom_range(5, 9));
        bus.cfg_count = NPULSE_W'($urandom_range(3, 6));
        bus.cfg_edge  = 2'b00;
        bus.cfg_rearm = 1'b0;
      end
      bus.arm = 1'b1;
      bus.abort = (c == ab);
      trigger_in = raw_w[c];
      @(negedge timerclk);
      check({tag, ".trigger"}, c, trigger, e_trig[c]);
      check({tag, ".busy"}, c, bus.busy, e_busy[c]);
      check({tag, ".armed"}, c, bus.armed, e_armed[c]);
      check({tag, ".done"}, c, bus.done, e_done[c]);
      if (c >= 1) check({tag, ".missed"}, c, bus.missed_cnt, e_miss[c]);
      if (e_idx_ok[c]) check({tag, ".idx"}, c, bus.pulse_idx, e_idx[c]);
    end
  endtask

  initial begin
    bit b;
    int ab;
    bus.cfg_delay = '0; bus.cfg_width = '0; bus.cfg_gap = '0; bus.cfg_count = '0;
    bus.cfg_edge = '0; bus.cfg_rearm = 1'b0; bus.arm = 1'b0; bus.abort = 1'b0;

    // Reset state.
    #12;
    check("rst.trigger", 0, trigger, 0);
    check("rst.busy", 0, bus.busy, 0);
    check("rst.armed", 0, bus.armed, 0);
    check("rst.done", 0, bus.done, 0);
    check("rst.idx", 0, bus.pulse_idx, 0);
    check("rst.missed", 0, bus.missed_cnt, 0);
    @(posedge timerclk); #1 reset = 1'b1;

    // Basic single pulse, rising edge.
    for (int c = 0; c < 40; c++) raw_w[c] = (c >= 3);
    run_scn("basic", 10, 3, 0, 1, 0, 0, 40, -1, 0);

    // Zero fields are fixed up to one.
    for (int c = 0; c < 20; c++) raw_w[c] = (c >= 2);
    run_scn("zeros", 0, 0, 0, 0, 0, 0, 20, -1, 0);

    // Three-pulse train.
    for (int c = 0; c < 50; c++) raw_w[c] = (c >= 2);
    run_scn("train3", 3, 2, 4, 3, 0, 0, 50, -1, 0);

    // Many edges during a long delay saturate the missed counter.
    for (int c = 0; c < 1130; c++)
      raw_w[c] = (c < 2) ? 1'b0 : (c < 1100) ? (((c - 2) / 2) % 2 == 0) : 1'b0;
    run_scn("saturate", 1100, 2, 1, 1, 0, 0, 1130, -1, 0);

    // Falling edge with rearm, two triggers 20 cycles apart, cfg scrambled mid-run.
    for (int c = 0; c < 60; c++) raw_w[c] = !((c >= 3 && c < 10) || (c >= 23 && c < 30));
    run_scn("rearm", 5, 3, 2, 2, 1, 1, 60, -1, 1);

    // Abort in the middle of the first pulse.
    for (int c = 0; c < 30; c++) raw_w[c] = (c >= 2);
    run_scn("abort", 4, 6, 3, 2, 0, 0, 30, 11, 0);

    // Level mode with rearm: a held-high trigger fires back-to-back trains.
    for (int c = 0; c < 60; c++) raw_w[c] = (c >= 2);
    run_scn("level", 2, 2, 1, 2, 3, 1, 60, -1, 0);

    // Asynchronous reset asserted mid-DELAY.
    raw_w[0] = 1'b0;
    park();
    for (int c = 0; c <= 10; c++) begin
      @(posedge timerclk); #1;
      if (c == 0) begin
        bus.cfg_delay = 200; bus.cfg_width = 1; bus.cfg_gap = 1; bus.cfg_count = 1;
        bus.cfg_edge = 2'b11; bus.cfg_rearm = 1'b0;
      end
      bus.arm = 1'b1;
      trigger_in = 1'b1;
      @(negedge timerclk);
    end
    check("pre_rst.busy", 10, bus.busy, 1);
    check("pre_rst.missed", 10, bus.missed_cnt, 10 - SYNC - 1);
    #2 reset = 1'b0;
    #1;
    check("arst.trigger", 0, trigger, 0);
    check("arst.busy", 0, bus.busy, 0);
    check("arst.armed", 0, bus.armed, 0);
    check("arst.done", 0, bus.done, 0);
    check("arst.idx", 0, bus.pulse_idx, 0);
    check("arst.missed", 0, bus.missed_cnt, 0);
    @(posedge timerclk); #1;
    bus.arm = 1'b0; trigger_in = 1'b0;
    @(posedge timerclk); #1 reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge timerclk);
      check("post_rst.busy", c, bus.busy, 0);
      check("post_rst.armed", c, bus.armed, 0);
      check("post_rst.trigger", c, trigger, 0);
    end

    // Randomised scenarios.
    for (int s = 0; s < 8; s++) begin
      b = 1'($urandom_range(0, 1));
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 5) == 0) b = ~b;
        raw_w[c] = b;
      end
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 100)) : -1;
      run_scn($sformatf("rand%0d", s), int'($urandom_range(0, 12)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 1)), 150, ab, 0);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/delay_pulse_gen.md
Name: delay_pulse_gen

Overview:
- Parametrised next-generation trigger delay engine in the `timerclk` domain.
- Waits, once armed, for a selectable edge on an asynchronous external trigger, counts a programmable delay, then emits a programmable train of pulses with programmable width, gap and count.
- Adds auto-rearm, abort and missed-trigger accounting.
- Configuration arrives from the register block as static inputs, already in the `timerclk` domain; the block latches it at arm time.

Parameters:
- CNT_W, 24: width of delay, width and gap counters and config fields.
- NPULSE_W, 8: width of pulse-count field and pulse index.
- SYNC_STAGES, 2: flip-flop stages on `trigger_in` (minimum 2).
- MISS_W, 8: width of saturating missed-trigger counter.

Ports:
- timerclk  in  1  sole clock.
- reset  in  1  asynchronous active-low reset; 0 resets all state.
- trigger_in  in  1  asynchronous external trigger.
- cfg_delay  in  CNT_W  cycles from trigger event to first pulse.
- cfg_width  in  CNT_W  pulse high time in cycles; 0 treated as 1.
- cfg_gap  in  CNT_W  low time between pulses; 0 treated as 1.
- cfg_count  in  NPULSE_W  pulses per trigger; 0 treated as 1.
- cfg_edge  in  2  00 rising, 01 falling, 10 both, 11 level-high.
- cfg_rearm  in  1  1 = return to ARMED after train instead of IDLE.
- arm  in  1  level; rising edge of arm (registered) arms the block.
- abort  in  1  synchronous; forces IDLE.
- trigger  out  1  registered pulse output.
- busy  out  1  high in DELAY, PULSE or GAP.
- armed  out  1  high in ARMED.
- done  out  1  one-cycle strobe when the last pulse's high time ends.
- pulse_idx  out  NPULSE_W  index of current or last pulse (0-based).
- missed_cnt  out  MISS_W  triggers seen while busy; saturates at all-ones.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Shadow config 0.
  - Synchroniser flops 0.
  - Previous-arm flop 0.
- Synchroniser: `trigger_in` passes through SYNC_STAGES flops giving `ts`. A further flop gives `ts_d`.
- Event definition, `evt`, is combinational on `ts` and `ts_d`:
  - Rising: `ts & ~ts_d`.
  - Falling: `~ts & ts_d`.
  - Both: `ts ^ ts_d`.
  - Level: `ts`.
- Arm edge `arm_r`: `arm` high while its registered copy is low.
- IDLE:
  - On `arm_r`, latch all `cfg_*` into shadow registers, with zero-fixups applied, and go to ARMED.
  - Config changes at other times have no effect until the next arm.
- ARMED: on `evt`, load delay counter with `shadow_delay`, clear `pulse_idx`, go to DELAY.
- DELAY:
  - Counter 0 → go to PULSE next cycle, load width counter with `shadow_width`.
  - Otherwise decrement.
  - Result: `trigger` rises exactly `shadow_delay+1` cycles after the `evt` cycle.
- PULSE:
  - `trigger` = 1.
  - Width counter decrements from `shadow_width`; high time is exactly `shadow_width` cycles.
  - On last cycle:
    - If `pulse_idx == shadow_count-1`: assert `done` for one cycle, go to IDLE, or to ARMED if `shadow_rearm`.
    - Else: `pulse_idx+1`, go to GAP with `shadow_gap` loaded.
- GAP: `trigger` = 0 for exactly `shadow_gap` cycles, then PULSE with width reloaded.
- `trigger`, `busy` and `armed` are registered and decoded from next state, so they change on the same edge as the state.
- Missed triggers: `evt` while in DELAY, PULSE or GAP increments `missed_cnt` (saturating). It is not cleared by the train. It is cleared only by reset or `arm_r`.
- Auto-rearm: after `done`, ARMED is entered in the same cycle as `trigger` falls. An `evt` on the very next cycle is accepted. Shadow config is not re-latched.
- Abort:
  - Has priority over all transitions in any state.
  - Next cycle: state IDLE, `trigger`=0, `busy`=0, `armed`=0, no `done`.
  - `pulse_idx` and `missed_cnt` hold.
- `arm_r` coincident with abort: abort wins.
- `arm_r` in a non-IDLE state: ignored.
- Level mode with `rearm`: a held-high trigger retriggers immediately after each train.
- Counters never wrap. Max delay is 2^CNT_W−1, giving 2^CNT_W cycles of trigger latency.

Test Plan:
- cfg_delay=10, width=3, count=1, rising; arm, pulse trigger_in → `trigger` high 3 cycles starting 11 cycles after `evt` (SYNC_STAGES+1 later than raw edge); `done` on last high cycle; state IDLE.
- delay=0, width=0, gap=0, count=0 → single 1-cycle pulse 1 cycle after `evt`; zero-fixups verified.
- count=3, width=2, gap=4 → pattern 2 high, 4 low, 2 high, 4 low, 2 high; `pulse_idx` 0,1,2; one `done`.
- 5 extra trigger edges during DELAY with `missed_cnt` at all-ones−2 → `missed_cnt` saturates at 255; train unaffected.
- rearm=1, falling edge; two triggers 20 cycles apart → two full trains; `armed` high between trains; cfg changed mid-run ignored.
- abort mid-PULSE, then assert reset (0) mid-DELAY → `trigger` low next cycle, IDLE; reset clears all outputs asynchronously; no `done`.
